// File: rtl/pip_pkg.sv
// pip_pkg: shared encodings for the pipeline hazard controller
package pip_pkg;
  typedef enum logic [1:0] {FWD_RF = 2'b00, FWD_WB = 2'b01, FWD_MEM = 2'b10} fwd_e;
  typedef enum logic {RUN = 1'b0, WAIT = 1'b1} state_e;
endpackage

// File: rtl/pip_hazard_ctrl_if.sv
// pip_hazard_ctrl_if: pipeline-to-hazard-controller signal bundle
interface pip_hazard_ctrl_if #(parameter int CNT_W = 32);
  logic [4:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
  logic ex_rdEn, ex_memRd, mem_rdEn, wb_rdEn, branch_taken, mem_req, dmem_ready;
  logic pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
  logic if_id_flush, id_ex_flush, mem_wb_flush;
  logic [1:0] fwd_a, fwd_b;
  logic timeout_err;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
  modport master (
    output id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, ex_rdEn, ex_memRd, mem_rd, mem_rdEn,
           wb_rd, wb_rdEn, branch_taken, mem_req, dmem_ready,
    input  pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_flush,
           mem_wb_flush, fwd_a, fwd_b, timeout_err, stall_cnt, flush_cnt
  );
  modport slave (
    input  id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, ex_rdEn, ex_memRd, mem_rd, mem_rdEn,
           wb_rd, wb_rdEn, branch_taken, mem_req, dmem_ready,
    output pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_flush,
           mem_wb_flush, fwd_a, fwd_b, timeout_err, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pip_fwd_unit.sv
// pip_fwd_unit: EX operand forwarding selects, MEM over WB, forced to RF when killed
module pip_fwd_unit
  import pip_pkg::*;
(
  input  logic       kill,
  input  logic [4:0] ex_rs1,
  input  logic [4:0] ex_rs2,
  input  logic [4:0] mem_rd,
  input  logic       mem_rdEn,
  input  logic [4:0] wb_rd,
  input  logic       wb_rdEn,
  output logic [1:0] fwd_a,
  output logic [1:0] fwd_b
);
  function automatic logic [1:0] sel(input logic [4:0] rs, input logic [4:0] mrd, input logic men,
                                     input logic [4:0] wrd, input logic wen);
    return (men && mrd != 5'd0 && mrd == rs) ? FWD_MEM :
           (wen && wrd != 5'd0 && wrd == rs) ? FWD_WB : FWD_RF;
  endfunction
  always_comb begin
    fwd_a = kill ? FWD_RF : sel(ex_rs1, mem_rd, mem_rdEn, wb_rd, wb_rdEn);
    fwd_b = kill ? FWD_RF : sel(ex_rs2, mem_rd, mem_rdEn, wb_rd, wb_rdEn);
  end
endmodule

// File: rtl/pip_hazard_ctrl.sv
// pip_hazard_ctrl: pipeline enables/flushes, forwarding, dmem-wait FSM and perf counters
module pip_hazard_ctrl
  import pip_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input logic            clk,
  input logic            rst,
  pip_hazard_ctrl_if.slave h
);
  localparam int WW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WW-1:0] TMAX = WW'(MEM_TIMEOUT);
  state_e           state;
  logic [WW-1:0]    wait_cnt;
  logic             timeout_q;
  logic [CNT_W-1:0] stall_q, flush_q;
  logic             memwait, loaduse, go, pc_en, br_flush;
  assign memwait  = h.mem_req && !h.dmem_ready;
  assign loaduse  = h.ex_memRd && h.ex_rdEn && h.ex_rd != 5'd0 &&
                    (h.ex_rd == h.id_rs1 || h.ex_rd == h.id_rs2);
  // go: not frozen and either a taken branch squashes ID or there is no load-use bubble
  assign go       = !memwait && (h.branch_taken || !loaduse);
  assign br_flush = !rst && !memwait && h.branch_taken;
  assign pc_en    = !rst && go;
  assign h.pc_en        = pc_en;
  assign h.if_id_en     = rst || go;
  assign h.id_ex_en     = rst || !memwait;
  assign h.ex_mem_en    = rst || !memwait;
  assign h.mem_wb_en    = rst || !memwait;
  assign h.if_id_flush  = rst || (!memwait && h.branch_taken);
  assign h.id_ex_flush  = rst || (!memwait && (h.branch_taken || loaduse));
  assign h.mem_wb_flush = rst || memwait;
  assign h.timeout_err  = timeout_q;
  assign h.stall_cnt    = stall_q;
  assign h.flush_cnt    = flush_q;
  pip_fwd_unit u_fwd (
    .kill    (rst),
    .ex_rs1  (h.ex_rs1),
    .ex_rs2  (h.ex_rs2),
    .mem_rd  (h.mem_rd),
    .mem_rdEn(h.mem_rdEn),
    .wb_rd   (h.wb_rd),
    .wb_rdEn (h.wb_rdEn),
    .fwd_a   (h.fwd_a),
    .fwd_b   (h.fwd_b)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RUN;
      wait_cnt  <= '0;
      timeout_q <= 1'b0;
      stall_q   <= '0;
      flush_q   <= '0;
    end else begin
      stall_q <= stall_q + CNT_W'(!pc_en);
      flush_q <= flush_q + CNT_W'(br_flush);
      if (state == RUN) begin
        state    <= memwait ? WAIT : RUN;
        wait_cnt <= memwait ? WW'(1) : '0;
      end else if (memwait) begin
        wait_cnt <= (wait_cnt == TMAX) ? wait_cnt : wait_cnt + WW'(1);
        if (wait_cnt == TMAX) timeout_q <= 1'b1;
      end else begin
        state    <= RUN;
        wait_cnt <= '0;
      end
    end
  end
endmodule
